present_engine: RTL and testbench

Parametrised PRESENT block-cipher engine: successor to the fixed 80-bit encrypt/decrypt core. Supports 80- or 128-bit keys, per-block encrypt/decrypt selection, and valid/ready handshakes on key load, block input and block output. A key is expanded once into a 32-entry round-key store; any number of blocks are then processed at one round per cycle. Sits between the crypto datapath front-end and the result FIFO.

---
 rtl/present_pkg.sv | 81 ++++++++
 rtl/present_key_expand.sv | 89 ++++++++
 rtl/present_engine.sv | 155 +++++++++++++++
 tb/tb_present_engine.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/present_pkg.sv
// PRESENT cipher shared definitions: FSM state type, round constants,
// 4-bit S-box / inverse S-box, 64-bit S-box layers, bit permutation and
// its inverse, and the single-round encrypt/decrypt helpers.
package present_pkg;

  localparam int unsigned NUM_ROUNDS = 31;
  localparam int unsigned NUM_KEYS   = 32;

  localparam logic [4:0] RND_FIRST = 5'd0;
  localparam logic [4:0] RND_LAST  = 5'(NUM_ROUNDS - 1);

  typedef enum logic [2:0] {
    IDLE,
    EXPAND,
    READY,
    BUSY,
    DONE
  } state_t;

  // Nibble x of each table is the substitution for input x.
  localparam logic [63:0] SBOX_TBL     = 64'h2174_8FE3_DA09_B65C;
  localparam logic [63:0] SBOX_INV_TBL = 64'hA970_364B_D21C_8FE5;

  function automatic logic [3:0] sbox(input logic [3:0] x);
    return SBOX_TBL[{x, 2'b00} +: 4];
  endfunction

  function automatic logic [3:0] sbox_inv(input logic [3:0] x);
    return SBOX_INV_TBL[{x, 2'b00} +: 4];
  endfunction

  function automatic logic [63:0] sbox_layer(input logic [63:0] x);
    logic [63:0] y;
    y = '0;
    for (int unsigned n = 0; n < 16; n++) begin
      y[4*n +: 4] = sbox(x[4*n +: 4]);
    end
    return y;
  endfunction

  function automatic logic [63:0] sbox_inv_layer(input logic [63:0] x);
    logic [63:0] y;
    y = '0;
    for (int unsigned n = 0; n < 16; n++) begin
      y[4*n +: 4] = sbox_inv(x[4*n +: 4]);
    end
    return y;
  endfunction

  // Destination of source bit i in the permutation layer.
  function automatic int unsigned ppos(input int unsigned i);
    return (i == 63) ? 63 : (i * 16) % 63;
  endfunction

  function automatic logic [63:0] player(input logic [63:0] x);
    logic [63:0] y;
    y = '0;
    for (int unsigned i = 0; i < 64; i++) begin
      y[6'(ppos(i))] = x[i];
    end
    return y;
  endfunction

  function automatic logic [63:0] player_inv(input logic [63:0] x);
    logic [63:0] y;
    y = '0;
    for (int unsigned i = 0; i < 64; i++) begin
      y[i] = x[6'(ppos(i))];
    end
    return y;
  endfunction

  function automatic logic [63:0] round_enc(input logic [63:0] st, input logic [63:0] rk);
    return player(sbox_layer(st ^ rk));
  endfunction

  function automatic logic [63:0] round_dec(input logic [63:0] st, input logic [63:0] rk);
    return sbox_inv_layer(player_inv(st)) ^ rk;
  endfunction

endpackage

// File: rtl/present_key_expand.sv
// PRESENT key schedule: holds the working key register and the 32-entry
// round-key store; a load starts 32 expansion cycles.
//   load_i  : start expansion with key_i
//   done_o  : high during the final expansion cycle
//   addr_i  : round-key read address, rkey_o combinational data
//   last_o  : round key 31 (needed alongside rkey_o by the datapath)
module present_key_expand
  import present_pkg::*;
#(
  parameter int unsigned KEY_WIDTH = 80
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 load_i,
  input  logic [KEY_WIDTH-1:0] key_i,
  output logic                 done_o,
  input  logic [4:0]           addr_i,
  output logic [63:0]          rkey_o,
  output logic [63:0]          last_o
);

  logic [KEY_WIDTH-1:0] key_q, key_d;
  logic [KEY_WIDTH-1:0] key_rot, key_upd;
  logic [4:0]           cnt_q, cnt_d;
  logic                 busy_q, busy_d;
  logic [4:0]           rc;
  logic [63:0]          rk_q [NUM_KEYS];

  assign rc      = cnt_q + 5'd1;
  assign key_rot = {key_q[KEY_WIDTH-62:0], key_q[KEY_WIDTH-1:KEY_WIDTH-61]};

  if (KEY_WIDTH == 80) begin : g_k80
    always_comb begin
      key_upd         = key_rot;
      key_upd[79:76]  = sbox(key_rot[79:76]);
      key_upd[19:15]  = key_rot[19:15] ^ rc;
    end
  end else if (KEY_WIDTH == 128) begin : g_k128
    always_comb begin
      key_upd          = key_rot;
      key_upd[127:124] = sbox(key_rot[127:124]);
      key_upd[123:120] = sbox(key_rot[123:120]);
      key_upd[66:62]   = key_rot[66:62] ^ rc;
    end
  end else begin : g_bad_width
    $error("present_key_expand: KEY_WIDTH must be 80 or 128");
    assign key_upd = key_rot;
  end

  always_comb begin
    key_d  = key_q;
    cnt_d  = cnt_q;
    busy_d = busy_q;
    if (load_i) begin
      key_d  = key_i;
      cnt_d  = '0;
      busy_d = 1'b1;
    end else if (busy_q) begin
      key_d = key_upd;
      cnt_d = cnt_q + 5'd1;
      if (cnt_q == 5'd31) begin
        busy_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      key_q  <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
    end else begin
      key_q  <= key_d;
      cnt_q  <= cnt_d;
      busy_q <= busy_d;
    end
  end

  always_ff @(posedge clk) begin
    if (busy_q) begin
      rk_q[cnt_q] <= key_q[KEY_WIDTH-1 -: 64];
    end
  end

  assign done_o = busy_q && (cnt_q == 5'd31);
  assign rkey_o = rk_q[addr_i];
  assign last_o = rk_q[NUM_KEYS-1];

endmodule

// File: rtl/present_engine.sv
// PRESENT block-cipher engine, 80/128-bit key, one round per cycle.
//   key_valid/key_ready/key         : key load handshake
//   keys_loaded                     : round-key store valid
//   in_valid/in_ready/in_mode/in_data : block input (mode 1 = decrypt)
//   out_valid/out_ready/out_data    : result, held while out_valid
module present_engine
  import present_pkg::*;
#(
  parameter int unsigned KEY_WIDTH   = 80,
  parameter int unsigned BLOCK_WIDTH = 64
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   key_valid,
  output logic                   key_ready,
  input  logic [KEY_WIDTH-1:0]   key,
  output logic                   keys_loaded,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic                   in_mode,
  input  logic [BLOCK_WIDTH-1:0] in_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [BLOCK_WIDTH-1:0] out_data
);

  if (BLOCK_WIDTH != 64) begin : g_bad_block
    $error("present_engine: BLOCK_WIDTH must be 64");
  end

  state_t      state_q, state_d;
  logic [63:0] st_q, st_d;
  logic [63:0] out_q, out_d;
  logic [4:0]  rnd_q, rnd_d;
  logic        mode_q, mode_d;
  logic        kl_q, kl_d;
  logic        kr_q, ir_q, ov_q;

  logic        kx_load, kx_done;
  logic [63:0] rk, rk_last;
  logic [63:0] enc_y, dec_y;
  logic        key_hs;

  present_key_expand #(
    .KEY_WIDTH(KEY_WIDTH)
  ) u_kx (
    .clk    (clk),
    .rst    (rst),
    .load_i (kx_load),
    .key_i  (key),
    .done_o (kx_done),
    .addr_i (rnd_q),
    .rkey_o (rk),
    .last_o (rk_last)
  );

  assign key_hs = key_valid && kr_q;

  always_comb begin
    state_d = state_q;
    st_d    = st_q;
    out_d   = out_q;
    rnd_d   = rnd_q;
    mode_d  = mode_q;
    kl_d    = kl_q;
    kx_load = 1'b0;
    enc_y   = round_enc(st_q, rk);
    dec_y   = round_dec(st_q, rk);
    unique case (state_q)
      IDLE: begin
        if (key_hs) begin
          kx_load = 1'b1;
          state_d = EXPAND;
        end
      end
      EXPAND: begin
        if (kx_done) begin
          kl_d    = 1'b1;
          state_d = READY;
        end
      end
      READY: begin
        // A new key wins over a simultaneously offered block.
        if (key_hs) begin
          kx_load = 1'b1;
          kl_d    = 1'b0;
          state_d = EXPAND;
        end else if (in_valid && ir_q) begin
          mode_d  = in_mode;
          st_d    = in_mode ? (in_data ^ rk_last) : in_data;
          rnd_d   = in_mode ? RND_LAST : RND_FIRST;
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (mode_q) begin
          st_d = dec_y;
          if (rnd_q == RND_FIRST) begin
            out_d   = dec_y;
            state_d = DONE;
          end else begin
            rnd_d = rnd_q - 5'd1;
          end
        end else begin
          st_d = enc_y;
          if (rnd_q == RND_LAST) begin
            out_d   = enc_y ^ rk_last;
            state_d = DONE;
          end else begin
            rnd_d = rnd_q + 5'd1;
          end
        end
      end
      DONE: begin
        if (ov_q && out_ready) begin
          state_d = READY;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Handshake outputs are registered from the next state so they read low
  // for the cycle following a reset edge.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      st_q    <= '0;
      out_q   <= '0;
      rnd_q   <= '0;
      mode_q  <= 1'b0;
      kl_q    <= 1'b0;
      kr_q    <= 1'b0;
      ir_q    <= 1'b0;
      ov_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      st_q    <= st_d;
      out_q   <= out_d;
      rnd_q   <= rnd_d;
      mode_q  <= mode_d;
      kl_q    <= kl_d;
      kr_q    <= (state_d == IDLE) || (state_d == READY);
      ir_q    <= (state_d == READY);
      ov_q    <= (state_d == DONE);
    end
  end

  assign key_ready   = kr_q;
  assign in_ready    = ir_q;
  assign out_valid   = ov_q;
  assign keys_loaded = kl_q;
  assign out_data    = out_q;

endmodule

// File: tb/tb_present_engine.sv
module tb_present_engine;

  logic         clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst, key_valid, in_valid, in_mode, out_ready, w128;
  logic [127:0] key;
  logic [63:0]  in_data;

  logic         kv80, kv128, iv80, iv128;
  logic         kr80, kl80, ir80, ov80, kr128, kl128, ir128, ov128;
  logic [63:0]  od80, od128;
  logic         kr, kl, ir, ov;
  logic [63:0]  od;

  assign kv80  = key_valid & ~w128;
  assign kv128 = key_valid & w128;
  assign iv80  = in_valid & ~w128;
  assign iv128 = in_valid & w128;
  assign kr    = w128 ? kr128 : kr80;
  assign kl    = w128 ? kl128 : kl80;
  assign ir    = w128 ? ir128 : ir80;
  assign ov    = w128 ? ov128 : ov80;
  assign od    = w128 ? od128 : od80;

  present_engine #(.KEY_WIDTH(80), .BLOCK_WIDTH(64)) dut80 (
    .clk(clk), .rst(rst), .key_valid(kv80), .key_ready(kr80), .key(key[79:0]),
    .keys_loaded(kl80), .in_valid(iv80), .in_ready(ir80), .in_mode(in_mode),
    .in_data(in_data), .out_valid(ov80), .out_ready(out_ready), .out_data(od80)
  );

  present_engine #(.KEY_WIDTH(128), .BLOCK_WIDTH(64)) dut128 (
    .clk(clk), .rst(rst), .key_valid(kv128), .key_ready(kr128), .key(key),
    .keys_loaded(kl128), .in_valid(iv128), .in_ready(ir128), .in_mode(in_mode),
    .in_data(in_data), .out_valid(ov128), .out_ready(out_ready), .out_data(od128)
  );

  int total = 0;
  int bad   = 0;
  logic [63:0] sb [$];

  localparam logic [63:0] ONES     = 64'hFFFF_FFFF_FFFF_FFFF;
  localparam logic [63:0] CT80_Z_Z = 64'h5579_C138_7B22_8445;
  localparam logic [63:0] CT80_O_O = 64'h3333_DCD3_2132_10D2;
  localparam logic [63:0] CT80_O_Z = 64'hE72C_46C0_F594_5049;
  localparam logic [63:0] CT128_Z  = 64'h96DB_702A_2E69_00AF;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic load_key(input logic [127:0] k);
    int n = 0;
    key       = k;
    key_valid = 1'b1;
    while (!kr && n < 50) begin
      tick();
      n++;
    end
    chk1("key_ready_wait", kr, 1'b1);
    tick();
    key_valid = 1'b0;
    for (int i = 0; i < 31; i++) tick();
    chk1("keys_loaded_early", kl, 1'b0);
    tick();
    chk1("keys_loaded", kl, 1'b1);
    chk1("in_ready_after_key", ir, 1'b1);
  endtask

  task automatic accept(input logic mode, input logic [63:0] data);
    int n = 0;
    while (!ir && n < 50) begin
      tick();
      n++;
    end
    chk1("in_ready_wait", ir, 1'b1);
    in_mode  = mode;
    in_data  = data;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    in_data  = ONES ^ data;
    in_mode  = ~mode;
  endtask

  task automatic wait_out(input string tag);
    int n = 0;
    logic [63:0] e;
    while (!ov && n < 40) begin
      tick();
      n++;
    end
    chk({tag, "_latency"}, 64'(n), 64'd31);
    chk({tag, "_pending"}, 64'(sb.size()), 64'd1);
    e = (sb.size() > 0) ? sb.pop_front() : ~od;
    chk(tag, od, e);
  endtask

  task automatic drain();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk1("out_valid_drop", ov, 1'b0);
  endtask

  task automatic run(input string tag, input logic mode, input logic [63:0] data,
                     input logic [63:0] exp);
    accept(mode, data);
    sb.push_back(exp);
    wait_out(tag);
    drain();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0; key_valid = 1'b0; in_valid = 1'b0; in_mode = 1'b0;
    out_ready = 1'b0; w128 = 1'b0; key = '0; in_data = '0;
    tick();
    tick();
    chk1("rst_key_ready", kr, 1'b0);
    chk1("rst_in_ready", ir, 1'b0);
    chk1("rst_keys_loaded", kl, 1'b0);
    chk1("rst_out_valid", ov, 1'b0);
    chk("rst_out_data", od, 64'd0);
    rst = 1'b1;
    tick();
    chk1("key_ready_after_rst", kr, 1'b1);
    chk1("in_ready_idle", ir, 1'b0);

    // 80-bit vectors
    load_key(128'd0);
    run("enc80_k0", 1'b0, 64'd0, CT80_Z_Z);
    run("dec80_k0", 1'b1, CT80_Z_Z, 64'd0);
    load_key({48'd0, 80'hFFFF_FFFF_FFFF_FFFF_FFFF});
    run("enc80_k1_p1", 1'b0, ONES, CT80_O_O);
    run("dec80_k1", 1'b1, CT80_O_O, ONES);

    // back-pressure then back-to-back block
    accept(1'b0, 64'd0);
    sb.push_back(CT80_O_Z);
    wait_out("enc80_k1_p0");
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("hold_data", od, CT80_O_Z);
      chk1("hold_valid", ov, 1'b1);
      chk1("hold_in_ready", ir, 1'b0);
    end
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_mode   = 1'b0;
    in_data   = ONES;
    tick();
    out_ready = 1'b0;
    chk1("b2b_out_valid", ov, 1'b0);
    chk1("b2b_in_ready", ir, 1'b1);
    tick();
    in_valid = 1'b0;
    sb.push_back(CT80_O_O);
    wait_out("b2b_enc");
    drain();

    // key and block offered together in READY
    key       = 128'd0;
    key_valid = 1'b1;
    in_valid  = 1'b1;
    in_mode   = 1'b0;
    in_data   = 64'd0;
    tick();
    key_valid = 1'b0;
    in_valid  = 1'b0;
    chk1("coll_keys_loaded", kl, 1'b0);
    chk1("coll_in_ready", ir, 1'b0);
    chk1("coll_key_ready", kr, 1'b0);
    for (int i = 0; i < 31; i++) begin
      tick();
      chk1("coll_expand_kl", kl, 1'b0);
    end
    tick();
    chk1("coll_kl_set", kl, 1'b1);
    chk1("coll_no_output", ov, 1'b0);
    run("enc80_newkey", 1'b0, 64'd0, CT80_Z_Z);

    // reset in the middle of a block
    accept(1'b0, 64'd0);
    for (int i = 0; i < 15; i++) tick();
    rst = 1'b0;
    tick();
    chk1("midrst_key_ready", kr, 1'b0);
    chk1("midrst_in_ready", ir, 1'b0);
    chk1("midrst_keys_loaded", kl, 1'b0);
    chk1("midrst_out_valid", ov, 1'b0);
    chk("midrst_out_data", od, 64'd0);
    rst = 1'b1;
    tick();
    chk1("postrst_key_ready", kr, 1'b1);
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk1("postrst_refuse", ir, 1'b0);
      chk1("postrst_no_out", ov, 1'b0);
    end
    in_valid = 1'b0;
    load_key(128'd0);
    run("enc80_reload", 1'b0, 64'd0, CT80_Z_Z);

    // 128-bit key
    w128 = 1'b1;
    load_key(128'd0);
    run("enc128_k0", 1'b0, 64'd0, CT128_Z);
    run("dec128_k0", 1'b1, CT128_Z, 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
